// File: rtl/pcie_os_pkg.sv
// rtl/pcie_os_pkg.sv - symbol codes, FSM states and TS field record for the PIPE RX ordered-set decoder
package pcie_os_pkg;

  localparam logic [7:0] K_COM    = 8'hBC;
  localparam logic [7:0] K_SKP    = 8'h1C;
  localparam logic [7:0] K_IDL    = 8'h7C;
  localparam logic [7:0] K_PAD    = 8'hF7;
  localparam logic [7:0] D_TS1_ID = 8'h4A;
  localparam logic [7:0] D_TS2_ID = 8'h45;

  localparam logic [2:0] RXST_DEC_ERR  = 3'b100;
  localparam logic [2:0] RXST_DISP_ERR = 3'b111;

  typedef enum logic [2:0] {
    HUNT,
    HDR,
    TS,
    SKPS,
    EIOS
  } os_state_t;

  typedef struct packed {
    logic [7:0] link;
    logic [7:0] lane;
    logic       link_pad;
    logic       lane_pad;
    logic [7:0] n_fts;
    logic [7:0] rate;
    logic [7:0] ctrl;
    logic       ts_type;
  } ts_fields_t;

endpackage

// File: rtl/pcie_rx_sym_classify.sv
// rtl/pcie_rx_sym_classify.sv - combinational one-hot classification of one decoded PIPE symbol
module pcie_rx_sym_classify
  import pcie_os_pkg::*;
(
  input  logic [7:0] rx_data,
  input  logic       rx_datak,
  input  logic [2:0] rx_status,
  input  logic       rx_valid,
  output logic       is_com,
  output logic       is_skp,
  output logic       is_idl,
  output logic       is_pad,
  output logic       is_ts1id,
  output logic       is_ts2id,
  output logic       is_bad
);

  logic status_bad;
  logic good;

  assign status_bad = (rx_status == RXST_DEC_ERR) || (rx_status == RXST_DISP_ERR);
  assign is_bad     = rx_valid && status_bad;
  // Code flags only fire on a clean symbol, so they never overlap is_bad.
  assign good       = rx_valid && !status_bad;

  assign is_com   = good &&  rx_datak && (rx_data == K_COM);
  assign is_skp   = good &&  rx_datak && (rx_data == K_SKP);
  assign is_idl   = good &&  rx_datak && (rx_data == K_IDL);
  assign is_pad   = good &&  rx_datak && (rx_data == K_PAD);
  assign is_ts1id = good && !rx_datak && (rx_data == D_TS1_ID);
  assign is_ts2id = good && !rx_datak && (rx_data == D_TS2_ID);

endmodule

// File: rtl/pcie_rx_os_decoder.sv
// rtl/pcie_rx_os_decoder.sv - per-lane Gen1/Gen2 receive ordered-set decoder (TS1/TS2/SKP/EIOS)
module pcie_rx_os_decoder
  import pcie_os_pkg::*;
#(
  parameter int CNTWIDTH = 4,
  parameter int MAXSKP   = 5
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [7:0]          RxData,
  input  logic                RxDataK,
  input  logic                RxValid,
  input  logic [2:0]          RxStatus,
  input  logic                ts_cnt_clr,
  output logic                ts_valid,
  output logic                ts_type,
  output logic [7:0]          link_num,
  output logic                link_pad,
  output logic [7:0]          lane_num,
  output logic                lane_pad,
  output logic [7:0]          n_fts,
  output logic [7:0]          rate_id,
  output logic [7:0]          train_ctrl,
  output logic [CNTWIDTH-1:0] ts_count,
  output logic                skp_seen,
  output logic                eios_seen,
  output logic                os_error
);

  localparam int SKPW = $clog2(MAXSKP + 1);

  logic is_com, is_skp, is_idl, is_pad, is_ts1id, is_ts2id, is_bad;
  logic good_sym;

  pcie_rx_sym_classify u_classify (
    .rx_data  (RxData),
    .rx_datak (RxDataK),
    .rx_status(RxStatus),
    .rx_valid (RxValid),
    .is_com   (is_com),
    .is_skp   (is_skp),
    .is_idl   (is_idl),
    .is_pad   (is_pad),
    .is_ts1id (is_ts1id),
    .is_ts2id (is_ts2id),
    .is_bad   (is_bad)
  );

  assign good_sym = RxValid && !is_bad;

  os_state_t       state, state_n;
  logic [3:0]      idx, idx_n;
  logic [SKPW-1:0] skp_cnt, skp_cnt_n;
  logic [1:0]      idl_cnt, idl_cnt_n;
  ts_fields_t      sh, sh_n;
  ts_fields_t      cur;
  logic            have_prev;
  logic            sym_ok;
  logic            ts_fire, skp_fire, eios_fire, err_fire;

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    skp_cnt_n = skp_cnt;
    idl_cnt_n = idl_cnt;
    sh_n      = sh;
    sym_ok    = 1'b0;
    ts_fire   = 1'b0;
    skp_fire  = 1'b0;
    eios_fire = 1'b0;
    err_fire  = 1'b0;
    case (state)
      HUNT: begin
        if (is_com) state_n = HDR;
      end
      HDR: begin
        if (!good_sym) begin
          err_fire = 1'b1;
          state_n  = HUNT;
        end else if (is_skp) begin
          skp_cnt_n = SKPW'(1);
          state_n   = SKPS;
        end else if (is_idl) begin
          idl_cnt_n = 2'd1;
          state_n   = EIOS;
        end else if (is_pad || !RxDataK) begin
          sh_n.link     = RxData;
          sh_n.link_pad = is_pad;
          idx_n         = 4'd2;
          state_n       = TS;
        end else begin
          err_fire = 1'b1;
          state_n  = HUNT;
        end
      end
      TS: begin
        if (!good_sym) begin
          err_fire = 1'b1;
          state_n  = HUNT;
        end else if (is_com) begin
          // A fresh COM starts a new OS; keep it rather than hunting again.
          err_fire = 1'b1;
          state_n  = HDR;
        end else begin
          case (idx)
            4'd2: begin
              sym_ok        = is_pad || !RxDataK;
              sh_n.lane     = RxData;
              sh_n.lane_pad = is_pad;
            end
            4'd3: begin
              sym_ok     = !RxDataK;
              sh_n.n_fts = RxData;
            end
            4'd4: begin
              sym_ok    = !RxDataK;
              sh_n.rate = RxData;
            end
            4'd5: begin
              sym_ok    = !RxDataK;
              sh_n.ctrl = RxData;
            end
            4'd6: begin
              sym_ok       = is_ts1id || is_ts2id;
              sh_n.ts_type = is_ts2id;
            end
            default: sym_ok = sh.ts_type ? is_ts2id : is_ts1id;
          endcase
          if (!sym_ok) begin
            err_fire = 1'b1;
            state_n  = HUNT;
          end else if (idx == 4'd15) begin
            ts_fire = 1'b1;
            state_n = HUNT;
          end else begin
            idx_n = idx + 4'd1;
          end
        end
      end
      SKPS: begin
        if (!good_sym) begin
          err_fire = 1'b1;
          state_n  = HUNT;
        end else if (is_skp) begin
          if (skp_cnt >= SKPW'(MAXSKP)) begin
            err_fire = 1'b1;
            state_n  = HUNT;
          end else begin
            skp_cnt_n = skp_cnt + SKPW'(1);
          end
        end else begin
          skp_fire = 1'b1;
          state_n  = is_com ? HDR : HUNT;
        end
      end
      EIOS: begin
        if (!good_sym) begin
          err_fire = 1'b1;
          state_n  = HUNT;
        end else if (is_com) begin
          err_fire = 1'b1;
          state_n  = HDR;
        end else if (is_idl) begin
          if (idl_cnt == 2'd2) begin
            eios_fire = 1'b1;
            state_n   = HUNT;
          end else begin
            idl_cnt_n = idl_cnt + 2'd1;
          end
        end else begin
          err_fire = 1'b1;
          state_n  = HUNT;
        end
      end
      default: state_n = HUNT;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state     <= HUNT;
      idx       <= '0;
      skp_cnt   <= '0;
      idl_cnt   <= '0;
      sh        <= '0;
      cur       <= '0;
      have_prev <= 1'b0;
      ts_count  <= '0;
      ts_valid  <= 1'b0;
      skp_seen  <= 1'b0;
      eios_seen <= 1'b0;
      os_error  <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      skp_cnt   <= skp_cnt_n;
      idl_cnt   <= idl_cnt_n;
      sh        <= sh_n;
      ts_valid  <= ts_fire;
      skp_seen  <= skp_fire;
      eios_seen <= eios_fire;
      os_error  <= err_fire;
      if (ts_fire) cur <= sh;
      // The output registers double as the "previously accepted TS" record.
      if (ts_cnt_clr) begin
        ts_count  <= '0;
        have_prev <= 1'b0;
      end else if (err_fire) begin
        ts_count <= '0;
      end else if (ts_fire) begin
        have_prev <= 1'b1;
        if (have_prev && (sh == cur)) begin
          if (ts_count != {CNTWIDTH{1'b1}}) ts_count <= ts_count + CNTWIDTH'(1);
        end else begin
          ts_count <= CNTWIDTH'(1);
        end
      end
    end
  end

  assign ts_type    = cur.ts_type;
  assign link_num   = cur.link;
  assign link_pad   = cur.link_pad;
  assign lane_num   = cur.lane;
  assign lane_pad   = cur.lane_pad;
  assign n_fts      = cur.n_fts;
  assign rate_id    = cur.rate;
  assign train_ctrl = cur.ctrl;

endmodule
